// File: rtl/bloco_operativo_mac.sv
// Parametrised operative block: resultado = (+/-A +/-B +/-C) * K mod 2^WIDTH, with its own control FSM.
// Optional BLOCO_MAC_EARLY_EXIT_EN ends the multiply phase as soon as the remaining multiplier bits are zero.
module bloco_operativo_mac #(
    parameter int WIDTH  = 16,
    parameter int KWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [WIDTH-1:0]  C,
    input  logic [KWIDTH-1:0] K,
    input  logic [2:0]        modo,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  resultado
);

    localparam int CW = $clog2(KWIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(KWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACC_B,
        ACC_C,
        MUL,
        FIM
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  h_q, h_d;
    logic [KWIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  c_q, c_d;
    logic [1:0]        sub_q, sub_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            h_q     <= '0;
            x_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            b_q     <= '0;
            c_q     <= '0;
            sub_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            x_q     <= x_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            done_q  <= done_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
        end
    end

    // done is registered on the FIM exit edge so it coincides with the new resultado.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        x_d     = x_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        done_d  = 1'b0;
        b_d     = b_q;
        c_d     = c_q;
        sub_d   = sub_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    h_d     = modo[0] ? ({WIDTH{1'b0}} - A) : A;
                    x_d     = K;
                    s_d     = '0;
                    cnt_d   = '0;
                    b_d     = B;
                    c_d     = C;
                    sub_d   = modo[2:1];
                    state_d = ACC_B;
                end
            end
            ACC_B: begin
                h_d     = sub_q[0] ? (h_q - b_q) : (h_q + b_q);
                state_d = ACC_C;
            end
            ACC_C: begin
                h_d     = sub_q[1] ? (h_q - c_q) : (h_q + c_q);
                state_d = MUL;
`ifdef BLOCO_MAC_EARLY_EXIT_EN
                if (x_q == '0) begin
                    state_d = FIM;
                end
`endif
            end
            MUL: begin
                if (x_q[0]) begin
                    s_d = s_q + h_q;
                end
                h_d   = h_q << 1;
                x_d   = x_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIM;
                end
`ifdef BLOCO_MAC_EARLY_EXIT_EN
                if ((x_q >> 1) == '0) begin
                    state_d = FIM;
                end
`endif
            end
            FIM: begin
                res_d   = s_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign resultado = res_q;

endmodule

// File: tb/tb_bloco_operativo_mac.sv
// Directed self-checking bench for bloco_operativo_mac (WIDTH=16, KWIDTH=8).
// Honours BLOCO_MAC_EARLY_EXIT_EN when computing expected latencies.
module tb_bloco_operativo_mac;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A, B, C;
    logic [7:0]  K;
    logic [2:0]  modo;
    logic        busy;
    logic        done;
    logic [15:0] resultado;

    int vectors;
    int miscompares;

    bloco_operativo_mac #(.WIDTH(16), .KWIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .A(A),
        .B(B),
        .C(C),
        .K(K),
        .modo(modo),
        .busy(busy),
        .done(done),
        .resultado(resultado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected start-to-done edge count for a given K.
    function automatic int expLat(input int k);
`ifdef BLOCO_MAC_EARLY_EXIT_EN
        int msb;
        if (k == 0) return 3;
        msb = 0;
        for (int i = 0; i < 8; i++) if (k[i]) msb = i;
        return 4 + msb;
`else
        return (k >= 0 && k < 256) ? 11 : 0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation, measures latency to done and checks result and pulse width.
    task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [2:0] m, input logic [7:0] k,
                                 input logic [15:0] expRes);
        int lat;
        @(negedge clk);
        A = a; B = b; C = c; modo = m; K = k; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) lat = i;
        end
        checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat(int'(k))));
        checkOutput({tag, "_res"}, 32'(resultado), 32'(expRes));
        @(negedge clk);
        checkOutput({tag, "_donedrop"}, 32'(done), 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int gap;
        int dcount;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0; B = '0; C = '0; K = '0; modo = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_res", 32'(resultado), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus("add",      16'd5,      16'd3,  16'd1,  3'b000, 8'd4,   16'd36);
        applyStimulus("submix",   16'd5,      16'd3,  16'd1,  3'b010, 8'd255, 16'h02FD);
        applyStimulus("neg",      16'd0,      16'd1,  16'd0,  3'b010, 8'd2,   16'hFFFE);
        applyStimulus("wrap",     16'hFFFF,   16'd1,  16'd0,  3'b000, 8'd200, 16'h0000);
        applyStimulus("allsub",   16'd1,      16'd2,  16'd3,  3'b111, 8'd10,  16'hFFC4);
        applyStimulus("mix101",   16'd100,    16'd50, 16'd10, 3'b101, 8'd3,   16'hFF4C);
        applyStimulus("k1",       16'd7,      16'd0,  16'd0,  3'b000, 8'd1,   16'd7);
        applyStimulus("k0",       16'd9,      16'd4,  16'd2,  3'b000, 8'd0,   16'd0);
        applyStimulus("k128",     16'd3,      16'd0,  16'd0,  3'b000, 8'd128, 16'd384);

        // start held high, A changed after acceptance, back-to-back second operation.
        @(negedge clk);
        A = 16'd2; B = 16'd0; C = 16'd0; modo = 3'b000; K = 8'd3; start = 1'b1;
        @(posedge clk);
        #1 A = 16'd100;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) lat = i;
        end
        checkOutput("hs_lat1", 32'(lat), 32'(expLat(3)));
        checkOutput("hs_res1", 32'(resultado), 32'd6);
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("hs_reaccept", 32'(busy), 32'd1);
        gap = 0;
        for (int i = 2; i <= 40 && gap == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) gap = i;
        end
        checkOutput("hs_gap", 32'(gap), 32'(expLat(3) + 1));
        checkOutput("hs_res2", 32'(resultado), 32'd300);

        // start pulse while busy must be ignored.
        @(negedge clk);
        A = 16'd1; B = 16'd0; C = 16'd0; modo = 3'b000; K = 8'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcount = 0;
        @(negedge clk);
        dcount += int'(done);
        @(negedge clk);
        dcount += int'(done);
        A = 16'd50; K = 8'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            dcount += int'(done);
        end
        checkOutput("busyign_dones", 32'(dcount), 32'd1);
        checkOutput("busyign_res", 32'(resultado), 32'd2);
        checkOutput("busyign_idle", 32'(busy), 32'd0);

        // Reset asserted in the middle of the multiply phase.
        @(negedge clk);
        A = 16'd1; B = 16'd0; C = 16'd0; modo = 3'b000; K = 8'd255; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_res", 32'(resultado), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dcount += int'(done);
        end
        checkOutput("abort_nodone", 32'(dcount), 32'd0);
        checkOutput("abort_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
